// File: rtl/segre_mm_arbiter.sv
// Round-robin arbiter serialising N requester channels onto one main-memory port,
// with an optional response watchdog that aborts stalled transactions.
module segre_mm_arbiter #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned LANE_W      = 128,
  parameter int unsigned TYPE_W      = 2,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic                          clk_i,
  input  logic                          rsn_i,
  input  logic [NUM_CLIENTS-1:0]        cl_rd_i,
  input  logic [NUM_CLIENTS-1:0]        cl_wr_i,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr_i,
  input  logic [NUM_CLIENTS*WORD_W-1:0] cl_wr_data_i,
  input  logic [NUM_CLIENTS*TYPE_W-1:0] cl_wr_type_i,
  output logic [NUM_CLIENTS-1:0]        cl_rdy_o,
  output logic                          cl_err_o,
  output logic [LANE_W-1:0]             cl_rd_data_o,
  input  logic                          mm_data_rdy_i,
  input  logic [LANE_W-1:0]             mm_rd_data_i,
  output logic                          mm_rd_o,
  output logic                          mm_wr_o,
  output logic [ADDR_W-1:0]             mm_addr_o,
  output logic [ADDR_W-1:0]             mm_wr_addr_o,
  output logic [WORD_W-1:0]             mm_wr_data_o,
  output logic [TYPE_W-1:0]             mm_wr_data_type_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRdWait = 2'd1;
  localparam logic [1:0] StWrWait = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [IdxW-1:0]        gnt_q, gnt_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   mm_rd_q, mm_rd_d;
  logic                   mm_wr_q, mm_wr_d;
  logic [ADDR_W-1:0]      mm_addr_q, mm_addr_d;
  logic [ADDR_W-1:0]      mm_wr_addr_q, mm_wr_addr_d;
  logic [WORD_W-1:0]      mm_wr_data_q, mm_wr_data_d;
  logic [TYPE_W-1:0]      mm_wr_type_q, mm_wr_type_d;
  logic [LANE_W-1:0]      rd_data_q, rd_data_d;
  logic                   err_q, err_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_CLIENTS-1:0] req;
  logic                   scan_found;
  logic [IdxW-1:0]        scan_idx;
  logic [31:0]            cand;
  logic [IdxW-1:0]        ptr_after_gnt;

  assign req = cl_rd_i | cl_wr_i;

  // First requester at or after rr_ptr, wrapping modulo NUM_CLIENTS.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      if (!scan_found && req[IdxW'(cand)]) begin
        scan_found = 1'b1;
        scan_idx   = IdxW'(cand);
      end
    end
  end

  assign ptr_after_gnt = (32'(gnt_q) >= NUM_CLIENTS - 1) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    mm_rd_d      = mm_rd_q;
    mm_wr_d      = mm_wr_q;
    mm_addr_d    = mm_addr_q;
    mm_wr_addr_d = mm_wr_addr_q;
    mm_wr_data_d = mm_wr_data_q;
    mm_wr_type_d = mm_wr_type_q;
    rd_data_d    = rd_data_q;
    err_d        = err_q;
    timeout_d    = timeout_q;
    case (state_q)
      StIdle: begin
        if (scan_found) begin
          gnt_d = scan_idx;
          cnt_d = '0;
          err_d = 1'b0;
          // A client with both rd and wr pending gets its write served first.
          if (cl_wr_i[scan_idx]) begin
            state_d      = StWrWait;
            mm_wr_d      = 1'b1;
            mm_wr_addr_d = cl_addr_i[scan_idx*ADDR_W +: ADDR_W];
            mm_wr_data_d = cl_wr_data_i[scan_idx*WORD_W +: WORD_W];
            mm_wr_type_d = cl_wr_type_i[scan_idx*TYPE_W +: TYPE_W];
          end else begin
            state_d   = StRdWait;
            mm_rd_d   = 1'b1;
            mm_addr_d = cl_addr_i[scan_idx*ADDR_W +: ADDR_W];
          end
        end
      end
      StRdWait, StWrWait: begin
        cnt_d = cnt_q + 32'd1;
        // Memory completion wins over a watchdog expiry in the same cycle.
        if (mm_data_rdy_i) begin
          mm_rd_d = 1'b0;
          mm_wr_d = 1'b0;
          state_d = StResp;
          if (state_q == StRdWait) rd_data_d = mm_rd_data_i;
        end else if ((TIMEOUT != 0) && (cnt_d == TIMEOUT)) begin
          mm_rd_d   = 1'b0;
          mm_wr_d   = 1'b0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        state_d  = StIdle;
        rr_ptr_d = ptr_after_gnt;
        cnt_d    = '0;
        err_d    = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      mm_rd_q      <= 1'b0;
      mm_wr_q      <= 1'b0;
      mm_addr_q    <= '0;
      mm_wr_addr_q <= '0;
      mm_wr_data_q <= '0;
      mm_wr_type_q <= '0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      mm_rd_q      <= mm_rd_d;
      mm_wr_q      <= mm_wr_d;
      mm_addr_q    <= mm_addr_d;
      mm_wr_addr_q <= mm_wr_addr_d;
      mm_wr_data_q <= mm_wr_data_d;
      mm_wr_type_q <= mm_wr_type_d;
      rd_data_q    <= rd_data_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    cl_rdy_o = '0;
    if (state_q == StResp) cl_rdy_o[gnt_q] = 1'b1;
  end

  assign cl_err_o          = (state_q == StResp) && err_q;
  assign cl_rd_data_o      = rd_data_q;
  assign mm_rd_o           = mm_rd_q;
  assign mm_wr_o           = mm_wr_q;
  assign mm_addr_o         = mm_addr_q;
  assign mm_wr_addr_o      = mm_wr_addr_q;
  assign mm_wr_data_o      = mm_wr_data_q;
  assign mm_wr_data_type_o = mm_wr_type_q;
  assign busy_o            = (state_q != StIdle);
  assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// Directed bench for segre_mm_arbiter (4 clients, watchdog of 8) with a completion scoreboard.
module tb_segre_mm_arbiter;

  localparam int N = 4;

  typedef struct {
    int           cl;
    logic         err;
    logic         is_wr;
    logic [127:0] lane;
  } exp_t;

  logic           clk_i;
  logic           rsn_i;
  logic [N-1:0]   cl_rd, cl_wr;
  logic [N*32-1:0] cl_addr, cl_wdata;
  logic [N*2-1:0] cl_wtype;
  logic [N-1:0]   cl_rdy_o;
  logic           cl_err_o;
  logic [127:0]   cl_rd_data_o;
  logic           mm_data_rdy;
  logic [127:0]   mm_rd_data;
  logic           mm_rd_o, mm_wr_o;
  logic [31:0]    mm_addr_o, mm_wr_addr_o, mm_wr_data_o;
  logic [1:0]     mm_wr_data_type_o;
  logic           busy_o, timeout_o;

  int             want_rd[N], want_wr[N], got_rd[N], got_wr[N];
  logic [31:0]    addr[N], wdata[N];
  logic [1:0]     wtype[N];

  exp_t           sb[$];
  exp_t           mon_e;
  logic [127:0]   exp_lane;
  logic           prev_rdy;
  int             n_checks, n_err;
  int             mem_lat;
  logic           mem_en;
  int             hi;

  segre_mm_arbiter #(
    .NUM_CLIENTS(N), .ADDR_W(32), .WORD_W(32), .LANE_W(128), .TYPE_W(2), .TIMEOUT(8)
  ) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .cl_rd_i(cl_rd), .cl_wr_i(cl_wr), .cl_addr_i(cl_addr),
    .cl_wr_data_i(cl_wdata), .cl_wr_type_i(cl_wtype),
    .cl_rdy_o(cl_rdy_o), .cl_err_o(cl_err_o), .cl_rd_data_o(cl_rd_data_o),
    .mm_data_rdy_i(mm_data_rdy), .mm_rd_data_i(mm_rd_data),
    .mm_rd_o(mm_rd_o), .mm_wr_o(mm_wr_o), .mm_addr_o(mm_addr_o),
    .mm_wr_addr_o(mm_wr_addr_o), .mm_wr_data_o(mm_wr_data_o),
    .mm_wr_data_type_o(mm_wr_data_type_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // A client request is pending while it has asked for more than it has been given.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      cl_rd[c]             = (want_rd[c] != got_rd[c]);
      cl_wr[c]             = (want_wr[c] != got_wr[c]);
      cl_addr[c*32 +: 32]  = addr[c];
      cl_wdata[c*32 +: 32] = wdata[c];
      cl_wtype[c*2 +: 2]   = wtype[c];
    end
  end

  function automatic logic [127:0] lane_of(input logic [31:0] a);
    return {4{a ^ 32'h0000_1000 ^ 32'hA5A5_A5A5}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: answers in wait cycle mem_lat when enabled.
  initial begin
    int wcnt;
    wcnt        = 0;
    mm_data_rdy = 1'b0;
    mm_rd_data  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mm_data_rdy = 1'b0;
      if (mm_rd_o || mm_wr_o) begin
        wcnt++;
        if (mem_en && wcnt == mem_lat) begin
          mm_data_rdy = 1'b1;
          mm_rd_data  = mm_rd_o ? lane_of(mm_addr_o) : {4{32'hDEAD_0BAD}};
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Completion monitor: pops the scoreboard on every cl_rdy_o pulse.
  always @(negedge clk_i) begin
    if (cl_rdy_o != '0) begin
      if (sb.size() == 0) begin
        check("rdy_unexpected", 256'(cl_rdy_o), 256'(0));
      end else begin
        mon_e = sb.pop_front();
        check("rdy_onehot", 256'(cl_rdy_o), 256'(4'b0001 << mon_e.cl));
        check("rdy_err", 256'(cl_err_o), 256'(mon_e.err));
        check("rdy_lane", 256'(cl_rd_data_o), 256'(mon_e.lane));
        check("rdy_after_mm", 256'(prev_rdy), 256'(!mon_e.err));
        if (mon_e.is_wr) got_wr[mon_e.cl]++;
        else got_rd[mon_e.cl]++;
      end
    end
    prev_rdy = mm_data_rdy;
  end

  task automatic push_rd(input int c, input logic [31:0] a);
    exp_lane = lane_of(a);
    sb.push_back('{cl: c, err: 1'b0, is_wr: 1'b0, lane: exp_lane});
  endtask

  task automatic push_wr(input int c);
    sb.push_back('{cl: c, err: 1'b0, is_wr: 1'b1, lane: exp_lane});
  endtask

  task automatic push_abort(input int c);
    sb.push_back('{cl: c, err: 1'b1, is_wr: 1'b0, lane: exp_lane});
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !busy_o) break;
    end
    check(tag, 256'(sb.size()), 256'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 256'({cl_rdy_o, cl_err_o, mm_rd_o, mm_wr_o, busy_o, timeout_o,
                               mm_wr_data_type_o}), 256'(0));
    check({tag, "_addr"}, 256'({mm_addr_o, mm_wr_addr_o, mm_wr_data_o}), 256'(0));
    check({tag, "_lane"}, 256'(cl_rd_data_o), 256'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: observed no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    exp_lane = '0;
    prev_rdy = 1'b0;
    mem_en   = 1'b1;
    mem_lat  = 1;
    for (int c = 0; c < N; c++) begin
      want_rd[c] = 0; want_wr[c] = 0; got_rd[c] = 0; got_wr[c] = 0;
      addr[c] = 32'h4000 + 32'(c) * 32'h100; wdata[c] = '0; wtype[c] = '0;
    end
    rsn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_zero("reset");
    rsn_i = 1'b1;

    // Fairness: all clients read from reset, client 0 asks twice.
    @(negedge clk_i);
    for (int c = 0; c < N; c++) want_rd[c]++;
    want_rd[0]++;
    push_rd(0, addr[0]); push_rd(1, addr[1]); push_rd(2, addr[2]); push_rd(3, addr[3]);
    push_rd(0, addr[0]);
    wait_done("fair_drain");

    // Single read, memory answers in third wait cycle.
    mem_lat = 3;
    addr[0] = 32'h0000_1000;
    want_rd[0]++;
    push_rd(0, addr[0]);
    @(negedge clk_i);
    check("rd_busy", 256'(busy_o), 256'(1));
    hi = 0;
    while (mm_rd_o && hi < 20) begin
      hi++;
      check("rd_addr_held", 256'(mm_addr_o), 256'(32'h1000));
      @(negedge clk_i);
    end
    check("rd_high_cycles", 256'(hi), 256'(3));
    wait_done("rd_drain");
    check("rd_lane_a5", 256'(cl_rd_data_o), 256'({4{32'hA5A5_A5A5}}));

    // Write, client 1; data changes after grant must be ignored.
    mem_lat  = 2;
    addr[1]  = 32'h2004;
    wdata[1] = 32'hDEAD_BEEF;
    wtype[1] = 2'b00;
    want_wr[1]++;
    push_wr(1);
    @(negedge clk_i);
    check("wr_ctl", 256'({mm_wr_o, mm_rd_o}), 256'(2'b10));
    check("wr_addr", 256'(mm_wr_addr_o), 256'(32'h2004));
    check("wr_data", 256'(mm_wr_data_o), 256'(32'hDEAD_BEEF));
    check("wr_type", 256'(mm_wr_data_type_o), 256'(2'b00));
    wdata[1] = 32'h0;
    @(negedge clk_i);
    check("wr_data_latched", 256'({mm_wr_o, mm_wr_data_o}), 256'({1'b1, 32'hDEAD_BEEF}));
    wait_done("wr_drain");
    check("wr_lane_kept", 256'(cl_rd_data_o), 256'({4{32'hA5A5_A5A5}}));

    // Same client rd+wr: write first, then read in a later grant.
    mem_lat  = 1;
    addr[1]  = 32'h3000;
    wdata[1] = 32'h1234_5678;
    wtype[1] = 2'b10;
    want_wr[1]++;
    want_rd[1]++;
    push_wr(1);
    push_rd(1, 32'h3000);
    @(negedge clk_i);
    check("rdwr_first_wr", 256'({mm_wr_o, mm_rd_o, mm_wr_addr_o}), 256'({2'b10, 32'h3000}));
    wait_done("rdwr_drain");

    // Memory answers in the last allowed wait cycle: must not abort.
    mem_lat = 8;
    addr[0] = 32'h5000;
    want_rd[0]++;
    push_rd(0, addr[0]);
    wait_done("lat8_drain");
    check("lat8_no_timeout", 256'(timeout_o), 256'(0));

    // Watchdog abort on client 2.
    mem_en  = 1'b0;
    addr[2] = 32'h6000;
    want_rd[2]++;
    push_abort(2);
    @(negedge clk_i);
    hi = 0;
    while (mm_rd_o && hi < 20) begin
      hi++;
      @(negedge clk_i);
    end
    check("to_high_cycles", 256'(hi), 256'(8));
    wait_done("to_drain");
    repeat (5) @(negedge clk_i);
    check("to_sticky", 256'({timeout_o, busy_o}), 256'(2'b10));

    // Reset during client 3 read wait.
    addr[3] = 32'h7000;
    want_rd[3]++;
    repeat (3) @(negedge clk_i);
    check("pre_rst_wait", 256'({mm_rd_o, mm_addr_o}), 256'({1'b1, 32'h7000}));
    rsn_i = 1'b0;
    #1;
    check_zero("mid_rst");
    want_rd[3]--;
    exp_lane = '0;
    @(negedge clk_i);
    rsn_i   = 1'b1;
    mem_en  = 1'b1;
    mem_lat = 1;
    addr[1] = 32'h8000;
    addr[3] = 32'h9000;
    want_rd[1]++;
    want_rd[3]++;
    push_rd(1, 32'h8000);
    push_rd(3, 32'h9000);
    @(negedge clk_i);
    check("post_rst_gnt1", 256'({mm_rd_o, mm_addr_o}), 256'({1'b1, 32'h8000}));
    wait_done("post_rst_drain");
    check("post_rst_no_to", 256'(timeout_o), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
